fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side controller of the asynchronous FIFO, running entirely in the write clock domain.
//  - Accepts producer writes through a valid/ready handshake and drives the write port of the dual-port RAM.
//  - Keeps the binary and Gray write pointers.
//  - Brings the read-domain Gray pointer into this domain through the 2-FF sync block.
//  - Generates full, almost_full, a fill count and a sticky overflow error.
// PARAMETERS
//  ADDR_W     4   RAM address width; depth = 2**ADDR_W
//  DATA_W     8   data word width
//  AF_THRESH  12  almost_full asserts when fill count >= AF_THRESH (1..2**ADDR_W)
// PORTS
//  Clk           in   1         write-domain clock, rising edge
//  reset         in   1         asynchronous, active-low reset (0 = reset)
//  wr_valid      in   1         producer has a word on wr_data
//  wr_data       in   DATA_W    producer data
//  wr_ready      out  1         controller can accept a word this cycle
//  rd_ptr_gray   in   ADDR_W+1  read pointer (Gray), owned by the read clock domain
//  wr_ptr_gray   out  ADDR_W+1  registered write pointer (Gray), sent to the read domain
//  mem_we        out  1         RAM write enable
//  mem_waddr     out  ADDR_W    RAM write address
//  mem_wdata     out  DATA_W    RAM write data (= wr_data)
//  full          out  1         FIFO full (registered)
//  almost_full   out  1         fill count >= AF_THRESH (registered)
//  wr_count      out  ADDR_W+1  conservative fill level as seen from the write domain
//  overflow      out  1         sticky: a write was attempted while not ready
//  ovf_clr       in   1         clears overflow; a new violation in the same cycle wins
// BEHAVIOUR
//  Reset (reset=0, async):
//   - wptr_bin = wr_ptr_gray = 0; full = 0, almost_full = 0, overflow = 0, wr_count = 0.
//   - wr_ready = 0, mem_we = 0; FSM goes to INIT.
//  FSM (2 bits): INIT -> WARM -> RUN.
//   - INIT and WARM each last exactly one cycle after reset release.
//   - Purpose: the synchronised read pointer holds valid data before any write is accepted.
//   - wr_ready = 0 in INIT and WARM; in RUN, wr_ready = ~full.
//   - RUN is left only by reset. Reset asserted mid-write aborts that write: no RAM write, pointers zeroed.
//  Handshake:
//   - accept = wr_valid & wr_ready.
//   - mem_we = accept (combinational); mem_waddr = wptr_bin[ADDR_W-1:0]; mem_wdata = wr_data.
//   - wr_valid is never registered. The producer holds wr_data until it sees accept.
//  Pointers:
//   - wptr_next = wptr_bin + accept, with ADDR_W+1 bits; it wraps naturally.
//   - The MSB is the lap bit: mem_waddr goes from 2**ADDR_W-1 back to 0 while the MSB toggles.
//   - wr_ptr_gray <= bin2gray(wptr_next), registered, so exactly one bit changes per increment.
//  Read-pointer synchronisation:
//   - rq2 = 2-FF synchronised rd_ptr_gray; rbin = gray2bin(rq2).
//   - A read becomes visible here 2 Clk edges after rd_ptr_gray settles, +1 cycle for the flags.
//  Flags (all registered from *_next values):
//   - full <= (bin2gray(wptr_next) == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}).
//   - wr_count <= wptr_next - rbin, modulo 2**(ADDR_W+1). Range 0..2**ADDR_W; it never reads above depth.
//   - almost_full <= (wptr_next - rbin) >= AF_THRESH.
//   - Flags are pessimistic: they deassert late after reads and never assert late after writes.
//  Boundaries:
//   - Write accepted that fills the last slot: full = 1 on the next cycle; wr_ready = 0 from then on.
//   - Full with no reads: the state holds indefinitely; mem_we stays 0.
//   - overflow <= 1 when wr_valid & ~wr_ready & (state == RUN), else 0 if ovf_clr, else hold.
//   - wr_valid during INIT or WARM is back-pressure, not overflow.
//   - A read and a write in the same cycle: the write proceeds if ~full; the read is seen 2 cycles later.
// STRUCTURE
//  - Shared package fifo_pkg holds:
//    - functions bin2gray and gray2bin, parameterised by width;
//    - state localparams ST_INIT = 2'd0, ST_WARM = 2'd1, ST_RUN = 2'd2.
//  - Sub-module: one instance of sync with N = ADDR_W+1, Clk = Clk, reset = ~reset.
//    It carries rd_ptr_gray into rq2.
//  - Everything else is inline: FSM, pointer registers, flag logic.
// TESTING  (ADDR_W=4, AF_THRESH=12, read side modelled in the bench)
//  1. Reset release, wr_valid=1 held:
//     wr_ready=0 for 2 cycles, then 1; first write goes to mem_waddr=0; overflow stays 0.
//  2. 16 back-to-back writes, no reads:
//     mem_waddr 0..15; almost_full rises the cycle after the 12th accept; full=1 after the 16th;
//     wr_count=16; wr_ptr_gray=5'b11000.
//  3. Full, then wr_valid=1 for 3 cycles:
//     mem_we stays 0, overflow=1 sticky; ovf_clr pulse with wr_valid=0 -> overflow=0 next cycle.
//  4. Full, then bench advances rd_ptr_gray by 1:
//     full drops 3 cycles later, wr_count=15; one write is accepted at mem_waddr=0 with MSB=1 (wrap).
//  5. 40 writes interleaved with random reads:
//     every mem_waddr is in sequence mod 16; wr_ptr_gray changes 1 bit per accept; full never sets with wr_count<16.
//  6. reset pulled low mid-stream with wr_valid=1:
//     all outputs zero asynchronously, no mem_we; after release the 2-cycle warm-up repeats.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: Gray-code helpers and the
// write-side sequencing state encodings.
package fifo_pkg;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Helpers work on a wide container. Callers zero-extend a narrower code in
  // and truncate the result back; leading zeros leave both conversions exact.
  localparam int unsigned CODE_W = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus (one bit changes at a time).
module sync #(
  parameter int N = 2
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  // Two-stage capture of the foreign-domain bus; reset is active high here.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO (write clock domain only).
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | first cycle after reset, synchroniser still flushing
// WARM  | second cycle, synchronised read pointer becomes trustworthy
// RUN   | normal operation, writes accepted while not full
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int AF_THRESH = 12
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int PW = ADDR_W + 1;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic          accept;

  sync #(.N(PW)) u_rptr_sync (
    .Clk   (Clk),
    .reset (~reset),
    .d_i   (rd_ptr_gray),
    .q_o   (rq2)
  );

  // Sequencing state register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Warm-up sequence and handshake; writes are held off until the read pointer is valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_WARM;
      ST_WARM: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
    wr_ready = (state_q == ST_RUN) && !full_q;
    accept   = wr_valid && wr_ready;
  end

  // Next pointer and flags, all judged against the pointer after this cycle's write.
  always_comb begin
    wptr_d = wptr_q + PW'(accept);
    gray_d = PW'(bin2gray(CODE_W'(wptr_d)));
    rbin   = PW'(gray2bin(CODE_W'(rq2)));
    cnt_d  = wptr_d - rbin;
    full_d = (gray_d == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]});
    af_d   = (cnt_d >= PW'(AF_THRESH));
    ovf_d  = ovf_q;
    if (wr_valid && !wr_ready && (state_q == ST_RUN)) ovf_d = 1'b1;
    else if (ovf_clr)                                 ovf_d = 1'b0;
  end

  // Pointer and flag registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      gray_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      af_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      gray_q <= gray_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      af_q   <= af_d;
      ovf_q  <= ovf_d;
    end
  end

  assign mem_we      = accept;
  assign mem_waddr   = wptr_q[ADDR_W-1:0];
  assign mem_wdata   = wr_data;
  assign wr_ptr_gray = gray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_count    = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomised bench for fifo_wr_ctrl: the driver pushes each offered word into a
// scoreboard, a negedge monitor pops on every RAM write and checks all outputs
// against a fill-level model (writes accepted minus reads, seen with sync delay).
module tb_fifo_wr_ctrl;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic [4:0] rd_ptr_gray = '0;
  logic [4:0] wr_ptr_gray;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  fifo_wr_ctrl #(.ADDR_W(4), .DATA_W(8), .AF_THRESH(12)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_ptr_gray (wr_ptr_gray),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .full        (full),
    .almost_full (almost_full),
    .wr_count    (wr_count),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sb[$];
  int  w_acc = 0;
  int  rd_cnt = 0;
  int  rsh[3] = '{0, 0, 0};
  int  rel_edges = 0;
  bit  exp_ovf = 1'b0;
  bit  rd_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [4:0] gray5(input int n);
    int m;
    m = n % 32;
    return 5'(m ^ (m >> 1));
  endfunction

  always @(posedge Clk or negedge reset) begin
    if (!reset) rel_edges = 0;
    else if (rel_edges < 3) rel_edges++;
  end

  // Monitor / reference model.
  always @(negedge Clk) begin : mon
    int  fill;
    bit  run, e_full, e_ready, e_acc;
    logic [7:0] d;
    if (!reset) begin
      chk("rst_wr_ready", int'(wr_ready), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_wr_count", int'(wr_count), 0);
      chk("rst_overflow", int'(overflow), 0);
      sb.delete();
      w_acc = 0;
      exp_ovf = 1'b0;
      rsh = '{0, 0, 0};
    end else begin
      fill    = w_acc - rsh[2];
      run     = (rel_edges >= 2);
      e_full  = (fill == 16);
      e_ready = run && !e_full;
      chk("full", int'(full), int'(e_full));
      chk("almost_full", int'(almost_full), int'(fill >= 12));
      chk("wr_count", int'(wr_count), fill);
      chk("wr_ptr_gray", int'(wr_ptr_gray), int'(gray5(w_acc)));
      chk("wr_ready", int'(wr_ready), int'(e_ready));
      chk("overflow", int'(overflow), int'(exp_ovf));
      e_acc = wr_valid && e_ready;
      chk("mem_we", int'(mem_we), int'(e_acc));
      if (e_acc) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_empty: got write with no offered word (t=%0t)", $time);
        end else begin
          d = sb.pop_front();
          chk("mem_waddr", int'(mem_waddr), w_acc % 16);
          chk("mem_wdata", int'(mem_wdata), int'(d));
        end
        w_acc++;
      end
      if (wr_valid && !e_ready && run) exp_ovf = 1'b1;
      else if (ovf_clr)               exp_ovf = 1'b0;
      rsh[2] = rsh[1];
      rsh[1] = rsh[0];
      rsh[0] = rd_cnt;
    end
  end

  // Read-side model: random single-step reads of words already written.
  always @(posedge Clk) begin
    #1;
    if (rd_en && reset && ($urandom_range(0, 1) == 1) && (rd_cnt < w_acc)) begin
      rd_cnt++;
      rd_ptr_gray = gray5(rd_cnt);
    end
  end

  // Offer one word and hold it until a cycle with wr_ready has passed.
  task automatic put(input logic [7:0] d, input int budget);
    bit rdy;
    int k;
    sb.push_back(d);
    wr_data  = d;
    wr_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge Clk);
      rdy = wr_ready;
      @(posedge Clk);
      #1;
      if (rdy) break;
      k++;
      if (k >= budget) begin
        n_chk++;
        $display("FAIL put_timeout: word %0d not accepted in %0d cycles", d, budget);
        break;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge Clk);
    #1;
    reset = 1'b0;
    wr_valid = 1'b0;
    rd_cnt = 0;
    rd_ptr_gray = '0;
    repeat (cycles) @(posedge Clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1. warm-up with wr_valid held from reset release
    repeat (3) @(posedge Clk);
    #1;
    reset = 1'b1;
    chk("t1_ready_at_release", int'(wr_ready), 0);
    put(8'hA5, 10);
    wr_valid = 1'b0;
    chk("t1_overflow", int'(overflow), 0);
    chk("t1_ptr", int'(wr_ptr_gray), 1);

    // 2. sixteen back-to-back writes from empty
    do_reset(3);
    for (int i = 0; i < 16; i++) put(8'($urandom), 10);
    wr_valid = 1'b0;
    chk("t2_full", int'(full), 1);
    chk("t2_almost_full", int'(almost_full), 1);
    chk("t2_wr_count", int'(wr_count), 16);
    chk("t2_wr_ptr_gray", int'(wr_ptr_gray), 24);

    // 3. writes while full raise sticky overflow; clear it
    wr_valid = 1'b1;
    wr_data  = 8'h3C;
    repeat (3) @(posedge Clk);
    #1;
    wr_valid = 1'b0;
    chk("t3_overflow_set", int'(overflow), 1);
    @(posedge Clk);
    #1;
    chk("t3_overflow_sticky", int'(overflow), 1);
    ovf_clr = 1'b1;
    @(posedge Clk);
    #1;
    ovf_clr = 1'b0;
    chk("t3_overflow_clr", int'(overflow), 0);

    // 4. one read frees a slot three cycles later; next write wraps
    rd_cnt = 1;
    rd_ptr_gray = gray5(rd_cnt);
    repeat (2) @(posedge Clk);
    #1;
    chk("t4_full_held", int'(full), 1);
    @(posedge Clk);
    #1;
    chk("t4_full_drop", int'(full), 0);
    chk("t4_wr_count", int'(wr_count), 15);
    put(8'h5A, 10);
    wr_valid = 1'b0;
    chk("t4_wrap_ptr", int'(wr_ptr_gray), 25);
    chk("t4_full_again", int'(full), 1);

    // 5. forty writes against random reads
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      put(8'($urandom), 100);
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge Clk);
        #1;
      end
    end

    // 6. reset mid-stream with a word on the bus
    for (int i = 0; i < 3; i++) put(8'($urandom), 100);
    sb.push_back(8'hEE);
    wr_data  = 8'hEE;
    wr_valid = 1'b1;
    #2;
    reset = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("t6_async_ready", int'(wr_ready), 0);
    chk("t6_async_we", int'(mem_we), 0);
    chk("t6_async_full", int'(full), 0);
    chk("t6_async_af", int'(almost_full), 0);
    chk("t6_async_count", int'(wr_count), 0);
    chk("t6_async_ptr", int'(wr_ptr_gray), 0);
    chk("t6_async_ovf", int'(overflow), 0);
    chk("t6_async_waddr", int'(mem_waddr), 0);
    rd_cnt = 0;
    rd_ptr_gray = '0;
    repeat (4) @(posedge Clk);
    #1;
    wr_valid = 1'b0;
    reset = 1'b1;
    chk("t6_ready_at_release", int'(wr_ready), 0);
    for (int i = 0; i < 4; i++) put(8'($urandom), 10);
    wr_valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("t6_count_final", int'(wr_count), 4);
    chk("t6_sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
